// File: rtl/coef_frame_if.sv
// Byte-pin link from the host plus coefficient/start handshake toward the eigenvalue core.
// The slave modport is the loader; the master modport is the host/core side.
interface coef_frame_if;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned COEF_W = 32;

    logic [BYTE_W-1:0] din;
    logic              strobe;
    logic              sof;
    logic              core_busy;
    logic [COEF_W-1:0] a0;
    logic [COEF_W-1:0] a1;
    logic              start_calc;

    modport master (output din, strobe, sof, core_busy, input a0, a1, start_calc);
    modport slave  (input din, strobe, sof, core_busy, output a0, a1, start_calc);
endinterface

// File: rtl/coef_frame_loader.sv
// Synchronises the async byte pins, frames a0/a1 (+ optional XOR checksum) and launches the core.
// Optional feature macro: COEF_CHECKSUM_EN (9-byte frame with checksum check and err_chk).
module coef_frame_loader #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    coef_frame_if.slave  bus,
    output logic         loader_busy,
    output logic         err_chk,
    output logic         err_timeout,
    output logic         err_overrun
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned SH_W   = 64;
    localparam int unsigned CNT_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
`ifdef COEF_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(8);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(7);
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_PEND} state_t;

    logic [SYNC_STAGES-1:0] strobe_sync;
    logic [SYNC_STAGES-1:0] sof_sync;
    logic [BYTE_W-1:0]      din_sync [SYNC_STAGES];
    logic                   strobe_d;
    logic                   accept_c;
    logic [BYTE_W-1:0]      byte_in_c;
    logic                   sof_in_c;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [CNT_W-1:0]       tmo_cnt;
    logic [SH_W-1:0]        sh;
`ifdef COEF_CHECKSUM_EN
    logic [BYTE_W-1:0]      chk_acc;
    logic                   chk_bad;
`endif

    // Pin synchronisers and strobe rising-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_sync <= '0;
            sof_sync    <= '0;
            strobe_d    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) din_sync[i] <= '0;
        end else begin
            strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], bus.strobe};
            sof_sync    <= {sof_sync[SYNC_STAGES-2:0], bus.sof};
            strobe_d    <= strobe_sync[SYNC_STAGES-1];
            din_sync[0] <= bus.din;
            for (int i = 1; i < SYNC_STAGES; i++) din_sync[i] <= din_sync[i-1];
        end
    end

    assign accept_c  = strobe_sync[SYNC_STAGES-1] & ~strobe_d & ena;
    assign byte_in_c = din_sync[SYNC_STAGES-1];
    assign sof_in_c  = sof_sync[SYNC_STAGES-1];

`ifndef COEF_CHECKSUM_EN
    assign err_chk = 1'b0;
`endif

    // Framing FSM; a0/a1 are only ever loaded from the shadow on commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            idx            <= '0;
            tmo_cnt        <= '0;
            sh             <= '0;
            bus.a0         <= '0;
            bus.a1         <= '0;
            bus.start_calc <= 1'b0;
            loader_busy    <= 1'b0;
            err_timeout    <= 1'b0;
            err_overrun    <= 1'b0;
`ifdef COEF_CHECKSUM_EN
            chk_acc        <= '0;
            chk_bad        <= 1'b0;
            err_chk        <= 1'b0;
`endif
        end else begin
            bus.start_calc <= 1'b0;
            if (accept_c && sof_in_c && (state == S_IDLE || state == S_LOAD)) begin
                // Frame start (or restart): clears sticky errors in the same cycle
                sh[BYTE_W-1:0] <= byte_in_c;
                idx            <= IDX_W'(1);
                tmo_cnt        <= '0;
                state          <= S_LOAD;
                loader_busy    <= 1'b1;
                err_timeout    <= 1'b0;
                err_overrun    <= 1'b0;
`ifdef COEF_CHECKSUM_EN
                chk_acc        <= byte_in_c;
                chk_bad        <= 1'b0;
                err_chk        <= 1'b0;
`endif
            end else begin
                case (state)
                    S_IDLE: ;
                    S_LOAD: begin
                        if (accept_c) begin
                            tmo_cnt <= '0;
                            idx     <= idx + IDX_W'(1);
                            if (!idx[3]) sh[{idx[2:0], 3'b000} +: BYTE_W] <= byte_in_c;
`ifdef COEF_CHECKSUM_EN
                            if (!idx[3]) chk_acc <= chk_acc ^ byte_in_c;
                            else         chk_bad <= (chk_acc != byte_in_c);
`endif
                            if (idx == LAST_IDX) state <= S_CHECK;
                        end else if (ena) begin
                            if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                                err_timeout <= 1'b1;
                                tmo_cnt     <= '0;
                                state       <= S_IDLE;
                                loader_busy <= 1'b0;
                            end else begin
                                tmo_cnt <= tmo_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_CHECK: begin
`ifdef COEF_CHECKSUM_EN
                        if (chk_bad) begin
                            err_chk     <= 1'b1;
                            state       <= S_IDLE;
                            loader_busy <= 1'b0;
                        end else
`endif
                        begin
                            bus.a0 <= sh[31:0];
                            bus.a1 <= sh[63:32];
                            if (ena && !bus.core_busy) begin
                                bus.start_calc <= 1'b1;
                                state          <= S_IDLE;
                                loader_busy    <= 1'b0;
                            end else begin
                                state <= S_PEND;
                            end
                        end
                    end
                    S_PEND: begin
                        if (accept_c) err_overrun <= 1'b1;
                        if (ena && !bus.core_busy) begin
                            bus.start_calc <= 1'b1;
                            state          <= S_IDLE;
                            loader_busy    <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= S_IDLE;
                        loader_busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_coef_frame_loader.sv
// Directed bench for coef_frame_loader: framing, checksum, busy handshake, timeout, restart, reset.
module tb_coef_frame_loader;
    localparam int unsigned SYNC = 2;
    localparam int unsigned TMO  = 40;
`ifdef COEF_CHECKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic loader_busy, err_chk, err_timeout, err_overrun;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   start_cnt = 0;

    coef_frame_if bus();

    coef_frame_loader #(.SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus),
        .loader_busy(loader_busy), .err_chk(err_chk),
        .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.start_calc === 1'b1) start_cnt++;

    function automatic logic [7:0] fbyte(input logic [31:0] x, input logic [31:0] y, input int i);
        logic [63:0] v;
        logic [7:0]  c;
        v = {y, x};
        c = 8'h00;
        if (i < 8) return v[8*i +: 8];
        for (int j = 0; j < 8; j++) c = c ^ v[8*j +: 8];
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic s);
        @(negedge clk);
        bus.din = b; bus.sof = s; bus.strobe = 1'b1;
        repeat (4) @(negedge clk);
        bus.strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] x, input logic [31:0] y, input logic [7:0] mask);
        for (int i = 0; i < NB; i++)
            send_byte((i == 8) ? (fbyte(x, y, i) ^ mask) : fbyte(x, y, i), (i == 0));
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.a0 !== 32'h0) begin n_bad++; $display("FAIL reset_a0: got %h want 0", bus.a0); end
        n_cmp++; if (bus.a1 !== 32'h0) begin n_bad++; $display("FAIL reset_a1: got %h want 0", bus.a1); end
        n_cmp++; if ({bus.start_calc, loader_busy, err_chk, err_timeout, err_overrun} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 00000",
                              {bus.start_calc, loader_busy, err_chk, err_timeout, err_overrun});
        end
    endtask

    task automatic test_good_frame();
        logic [31:0] x;
        logic [31:0] y;
        int s0;
        x = 32'h12345678; y = 32'hFFFFFF80; s0 = start_cnt;
        for (int i = 0; i < NB - 1; i++) send_byte(fbyte(x, y, i), (i == 0));
        @(negedge clk);
        bus.din = fbyte(x, y, NB - 1); bus.sof = 1'b0; bus.strobe = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) bus.strobe = 1'b0;
            if (k == 3) begin
                n_cmp++; if (loader_busy !== 1'b1 || bus.start_calc !== 1'b0) begin
                    n_bad++; $display("FAIL good_check_cycle: busy=%b start=%b want 1 0", loader_busy, bus.start_calc); end
                n_cmp++; if (bus.a0 !== 32'h0) begin n_bad++; $display("FAIL good_a0_early: got %h want 0", bus.a0); end
            end
            if (k == 4) begin
                n_cmp++; if (bus.start_calc !== 1'b1) begin n_bad++; $display("FAIL good_start_lat: got %b want 1", bus.start_calc); end
                n_cmp++; if (bus.a0 !== x) begin n_bad++; $display("FAIL good_a0: got %h want %h", bus.a0, x); end
                n_cmp++; if (bus.a1 !== y) begin n_bad++; $display("FAIL good_a1: got %h want %h", bus.a1, y); end
                n_cmp++; if (loader_busy !== 1'b0) begin n_bad++; $display("FAIL good_idle: got %b want 0", loader_busy); end
            end
            if (k == 5) begin
                n_cmp++; if (bus.start_calc !== 1'b0) begin n_bad++; $display("FAIL good_pulse_width: got %b want 0", bus.start_calc); end
            end
        end
        repeat (4) @(negedge clk);
        n_cmp++; if (start_cnt - s0 !== 1) begin n_bad++; $display("FAIL good_pulses: got %0d want 1", start_cnt - s0); end
        n_cmp++; if ({err_chk, err_timeout, err_overrun} !== 3'b0) begin
            n_bad++; $display("FAIL good_errs: got %b want 000", {err_chk, err_timeout, err_overrun}); end
    endtask

    task automatic test_bad_checksum();
        int s0;
        s0 = start_cnt;
        send_frame(32'h44332211, 32'h88776655, 8'h01);
        repeat (3) @(negedge clk);
`ifdef COEF_CHECKSUM_EN
        n_cmp++; if (err_chk !== 1'b1) begin n_bad++; $display("FAIL chk_err: got %b want 1", err_chk); end
        n_cmp++; if (bus.a0 !== 32'h12345678 || bus.a1 !== 32'hFFFFFF80) begin
            n_bad++; $display("FAIL chk_keep: got %h %h want 12345678 ffffff80", bus.a0, bus.a1); end
        n_cmp++; if (start_cnt !== s0) begin n_bad++; $display("FAIL chk_nostart: got %0d want %0d", start_cnt, s0); end
`else
        n_cmp++; if (err_chk !== 1'b0) begin n_bad++; $display("FAIL chk_tied: got %b want 0", err_chk); end
        n_cmp++; if (bus.a0 !== 32'h44332211 || bus.a1 !== 32'h88776655) begin
            n_bad++; $display("FAIL nochk_commit: got %h %h want 44332211 88776655", bus.a0, bus.a1); end
        n_cmp++; if (start_cnt - s0 !== 1) begin n_bad++; $display("FAIL nochk_start: got %0d want 1", start_cnt - s0); end
`endif
        n_cmp++; if (loader_busy !== 1'b0) begin n_bad++; $display("FAIL chk_idle: got %b want 0", loader_busy); end
    endtask

    task automatic test_busy();
        int s0;
        s0 = start_cnt;
        bus.core_busy = 1'b1;
        send_frame(32'h80000000, 32'h00000001, 8'h00);
        send_byte(8'hAA, 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++; if (start_cnt !== s0 || loader_busy !== 1'b1) begin
            n_bad++; $display("FAIL busy_hold: starts=%0d busy=%b want %0d 1", start_cnt - s0, loader_busy, 0); end
        n_cmp++; if (err_overrun !== 1'b1 || err_chk !== 1'b0) begin
            n_bad++; $display("FAIL busy_overrun: ovr=%b chk=%b want 1 0", err_overrun, err_chk); end
        n_cmp++; if (bus.a0 !== 32'h80000000 || bus.a1 !== 32'h00000001) begin
            n_bad++; $display("FAIL busy_coef: got %h %h want 80000000 00000001", bus.a0, bus.a1); end
        bus.core_busy = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.start_calc !== 1'b1) begin n_bad++; $display("FAIL busy_release: got %b want 1", bus.start_calc); end
        @(negedge clk);
        n_cmp++; if (bus.start_calc !== 1'b0 || loader_busy !== 1'b0) begin
            n_bad++; $display("FAIL busy_after: start=%b busy=%b want 0 0", bus.start_calc, loader_busy); end
        n_cmp++; if (start_cnt - s0 !== 1) begin n_bad++; $display("FAIL busy_pulses: got %0d want 1", start_cnt - s0); end
    endtask

    task automatic test_timeout();
        int s0;
        s0 = start_cnt;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b0);
        @(negedge clk);
        bus.din = 8'h03; bus.sof = 1'b0; bus.strobe = 1'b1;
        for (int k = 1; k <= 3 + int'(TMO) + 1; k++) begin
            @(negedge clk);
            if (k == 4) bus.strobe = 1'b0;
            if (k == 3 + int'(TMO) - 1) begin
                n_cmp++; if (err_timeout !== 1'b0 || loader_busy !== 1'b1) begin
                    n_bad++; $display("FAIL tmo_early: err=%b busy=%b want 0 1", err_timeout, loader_busy); end
            end
            if (k == 3 + int'(TMO)) begin
                n_cmp++; if (err_timeout !== 1'b1 || loader_busy !== 1'b0) begin
                    n_bad++; $display("FAIL tmo_edge: err=%b busy=%b want 1 0", err_timeout, loader_busy); end
            end
        end
        n_cmp++; if (bus.a0 !== 32'h80000000 || start_cnt !== s0) begin
            n_bad++; $display("FAIL tmo_keep: a0=%h starts=%0d want 80000000 0", bus.a0, start_cnt - s0); end
        send_frame(32'hCAFEF00D, 32'h0BADBEEF, 8'h00);
        repeat (3) @(negedge clk);
        n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_clear: got %b want 0", err_timeout); end
        n_cmp++; if (bus.a0 !== 32'hCAFEF00D || bus.a1 !== 32'h0BADBEEF) begin
            n_bad++; $display("FAIL tmo_recover: got %h %h want cafef00d 0badbeef", bus.a0, bus.a1); end
    endtask

    task automatic test_restart();
        int s0;
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) send_byte(fbyte(32'h11111111, 32'h22222222, i), (i == 0));
        send_frame(32'h01234567, 32'h89ABCDEF, 8'h00);
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.a0 !== 32'h01234567 || bus.a1 !== 32'h89ABCDEF) begin
            n_bad++; $display("FAIL restart_coef: got %h %h want 01234567 89abcdef", bus.a0, bus.a1); end
        n_cmp++; if ({err_chk, err_timeout, err_overrun} !== 3'b0 || start_cnt - s0 !== 1) begin
            n_bad++; $display("FAIL restart_flags: errs=%b starts=%0d want 000 1",
                              {err_chk, err_timeout, err_overrun}, start_cnt - s0); end
    endtask

    task automatic test_restart_ena();
        int s0;
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) send_byte(fbyte(32'h55555555, 32'h66666666, i), (i == 0));
        ena = 1'b0;
        send_frame(32'h77777777, 32'h12121212, 8'h00);
        repeat (2 * TMO) @(negedge clk);
        n_cmp++; if (loader_busy !== 1'b1 || err_timeout !== 1'b0) begin
            n_bad++; $display("FAIL ena_frozen: busy=%b tmo=%b want 1 0", loader_busy, err_timeout); end
        n_cmp++; if (bus.a0 !== 32'h01234567 || start_cnt !== s0) begin
            n_bad++; $display("FAIL ena_noaccept: a0=%h starts=%0d want 01234567 0", bus.a0, start_cnt - s0); end
        ena = 1'b1;
        send_frame(32'h0F0F0F0F, 32'hF0F0F0F0, 8'h00);
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.a0 !== 32'h0F0F0F0F || bus.a1 !== 32'hF0F0F0F0 || start_cnt - s0 !== 1) begin
            n_bad++; $display("FAIL ena_resume: got %h %h starts=%0d want 0f0f0f0f f0f0f0f0 1",
                              bus.a0, bus.a1, start_cnt - s0); end
    endtask

    task automatic test_reset_mid();
        int s0;
        for (int i = 0; i < 6; i++) send_byte(fbyte(32'h31313131, 32'h42424242, i), (i == 0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.a0 !== 32'h0 || bus.a1 !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_coef: got %h %h want 0 0", bus.a0, bus.a1); end
        n_cmp++; if ({bus.start_calc, loader_busy, err_chk, err_timeout, err_overrun} !== 5'b0) begin
            n_bad++; $display("FAIL rstmid_flags: got %b want 00000",
                              {bus.start_calc, loader_busy, err_chk, err_timeout, err_overrun}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        s0 = start_cnt;
        repeat (20) @(negedge clk);
        n_cmp++; if (start_cnt !== s0 || loader_busy !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_quiet: starts=%0d busy=%b want 0 0", start_cnt - s0, loader_busy); end
        send_frame(32'h31313131, 32'h42424242, 8'h00);
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.a0 !== 32'h31313131 || bus.a1 !== 32'h42424242 || start_cnt - s0 !== 1) begin
            n_bad++; $display("FAIL rstmid_reload: got %h %h starts=%0d want 31313131 42424242 1",
                              bus.a0, bus.a1, start_cnt - s0); end
    endtask

    initial begin
        bus.din = 8'h00; bus.strobe = 1'b0; bus.sof = 1'b0; bus.core_busy = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (2) @(negedge clk);
        test_good_frame();
        test_bad_checksum();
        test_busy();
        test_timeout();
        test_restart();
        test_restart_ena();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/coef_frame_loader.md
Name: coef_frame_loader

Overview:
- Upstream stage of the eigenvalue core: assembles the two signed 32-bit coefficients a0/a1 from byte-wide user pins and issues a single-cycle start_calc.
- Pins (din, strobe, sof) are asynchronous to clk; the block synchronises them and frames the byte stream.
- Each frame can carry a checksum; the block validates it, handles inter-byte timeout, and handshakes with core_busy.
- Coefficients change only on a fully validated frame, so the core's data_rdy may be tied high.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the pin synchronisers (min 2).
- TIMEOUT_CYC, 1023, idle clk cycles allowed between bytes inside a frame before abort (min 1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- ena  in  1  block enable.
- din  in  8  data byte pins, asynchronous.
- strobe  in  1  byte strobe pin, asynchronous; a rising edge marks a byte.
- sof  in  1  start-of-frame pin, asynchronous; sampled with the byte.
- core_busy  in  1  high while the downstream core or output stage is busy.
- a0  out  32  coefficient 0, signed.
- a1  out  32  coefficient 1, signed.
- start_calc  out  1  one-cycle pulse that launches the core.
- loader_busy  out  1  high in any state other than IDLE.
- err_chk  out  1  sticky checksum error.
- err_timeout  out  1  sticky timeout error.
- err_overrun  out  1  sticky error: byte arrived while a start was pending.

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - byte index, checksum accumulator and timeout counter 0;
  - synchroniser flops 0.
- Synchronisation:
  - strobe, sof and din each pass through SYNC_STAGES flops.
  - One further flop on synced strobe gives rising-edge detect: byte_ev.
  - byte_ev is asserted SYNC_STAGES+1 cycles after the pin edge.
  - din and sof are taken from their synchronised copies in the byte_ev cycle.
  - Pins must be held stable for at least SYNC_STAGES+2 cycles around the strobe edge.
- Accepted byte = byte_ev and ena. With ena low:
  - no bytes are accepted;
  - the timeout counter is frozen;
  - start_calc is held 0;
  - synchronisers keep running.
- Frame layout:
  - index 0-3: a0 bytes, LSB first;
  - index 4-7: a1 bytes, LSB first;
  - index 8: checksum = XOR of bytes 0-7.
  - The byte with sof=1 is index 0.
- Assembly uses shadow registers sh0/sh1. a0/a1 are written only from the shadows, and only on commit.
- FSM states and transitions:
  - IDLE:
    - accepted byte with sof=1 -> store byte 0, index=1, go to LOAD;
    - bytes with sof=0 are ignored.
  - LOAD:
    - accepted byte with sof=1 -> restart: index 0 is this byte, checksum reinitialised, no error flag set;
    - other accepted byte -> store at the current index, index++, timeout counter cleared;
    - after index 8 is stored -> go to CHECK;
    - otherwise the counter increments each enabled cycle; on reaching TIMEOUT_CYC -> set err_timeout, go to IDLE, shadows discarded.
  - CHECK (1 cycle):
    - checksum matches -> commit shadows to a0/a1, go to PEND;
    - mismatch -> set err_chk, go to IDLE, a0/a1 unchanged.
  - PEND:
    - first enabled cycle with core_busy=0 -> start_calc=1 for exactly that cycle, go to IDLE;
    - any accepted byte here sets err_overrun and is dropped, sof included.
- Latency: final byte_ev in cycle N -> CHECK at N+1 -> a0/a1 valid at N+2 -> earliest start_calc at N+2.
- Sticky error flags are cleared when an accepted sof=1 byte is taken in IDLE or LOAD. The clear and that byte's store happen in the same cycle.
- Checksum runs in a single 8-bit XOR accumulator, with no width growth. a0/a1 are raw two's-complement byte concatenations, with no sign processing.
- Reset mid-frame aborts immediately: outputs return to 0 and no start_calc is issued.

Optional Feature:
- Macro: COEF_CHECKSUM_EN.
- Defined: the 9-byte frame with checksum validation, CHECK state and err_chk, exactly as above.
- Undefined:
  - the frame is 8 bytes;
  - after index 7 the FSM goes straight to a CHECK cycle that always commits;
  - err_chk is tied 0 and the checksum accumulator is not built.
- Latency is identical in both builds.

Test Plan:
- Good frame (checksum build), core_busy=0:
  - bytes 78 56 34 12 80 FF FF FF 77 (sof on the first);
  - required: a0=0x12345678, a1=0xFFFFFF80, one start_calc pulse at N+2, all err flags 0, loader_busy back to 0.
- Same frame with checksum 0x76:
  - required: a0/a1 keep their previous values, err_chk=1, no start_calc.
- Good frame with core_busy=1, released 20 cycles after CHECK:
  - required: start_calc stays 0 while busy, then a single pulse in the first cycle core_busy=0.
  - A byte sent during PEND sets err_overrun, and a0/a1 are unchanged by it.
- Three bytes, then silence:
  - required: err_timeout rises exactly TIMEOUT_CYC enabled cycles after the third byte, FSM returns to IDLE.
  - A following good frame clears the flag and commits.
- sof=1 byte at index 5, then a full good frame: commits the new frame only, no error.
  - Same restart with ena=0 during the bytes: nothing accepted, state and counter frozen.
- rst_n pulsed low at index 6:
  - required: all outputs 0 asynchronously, no start_calc afterwards.
  - A following frame loads normally.
